// File: rtl/serial_mag_compare_ctrl.sv
// ----------------------------------------------------------------------------
// serial_mag_compare_ctrl
//
// Bit-serial unsigned magnitude comparator. On an accepted start, both
// operands are loaded into shift registers. They are then walked MSB->LSB,
// one bit per clock, through a single cascaded 1-bit compare slice. The
// slice carries the "equal so far" and "greater so far" terms from the bits
// above.
//
// Flow: IDLE -> RUN (WIDTH cycles) -> DONE -> IDLE or RUN.
//  - busy is high for exactly the RUN cycles.
//  - The DONE state commits eq/gt/lt and raises the one-cycle done pulse.
//    All four are registered, so they appear together in the cycle that
//    follows DONE.
//  - A start seen in DONE is accepted at once, so operations can run
//    back-to-back with no IDLE cycle between them.
//  - The results hold until the next commit.
//
// Optional feature: define SERCMP_EARLY_EXIT_EN to leave RUN at the first
// differing bit. Equal operands still take WIDTH RUN cycles.
// ----------------------------------------------------------------------------
module serial_mag_compare_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             eq_acc;
    logic             gt_acc;
    logic [CNT_W-1:0] cnt;

    logic             a_bit;
    logic             b_bit;
    logic             eq_step;
    logic             gt_step;
    logic             run_last;
    logic             accept;

    // One step of the cascaded 1-bit compare, plus the RUN exit condition.
    // NOTE: every output of this block is given a value on every path,
    // so no latch is inferred.
    always_comb begin
        a_bit    = a_sh[WIDTH-1];
        b_bit    = b_sh[WIDTH-1];
        eq_step  = eq_acc & ~(a_bit ^ b_bit);
        gt_step  = gt_acc | (eq_acc & a_bit & ~b_bit);
        accept   = start && ((state == IDLE) || (state == DONE));
`ifdef SERCMP_EARLY_EXIT_EN
        run_last = (cnt == '0) || !eq_step;
`else
        run_last = (cnt == '0);
`endif
    end

    // Control FSM with its datapath and registered outputs.
    // NOTE: all state here uses non-blocking assignments, so every
    // right-hand side reads the pre-edge value. The shift registers are
    // ordinary flops, so they can be cleared by reset like the rest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            eq_acc <= 1'b0;
            gt_acc <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            eq     <= 1'b0;
            gt     <= 1'b0;
            lt     <= 1'b0;
        end else begin
            done <= 1'b0;

            case (state)
                IDLE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                RUN: begin
                    eq_acc <= eq_step;
                    gt_acc <= gt_step;
                    a_sh   <= a_sh << 1;
                    b_sh   <= b_sh << 1;
                    cnt    <= cnt - 1'b1;
                    if (run_last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end
                end

                DONE: begin
                    done  <= 1'b1;
                    eq    <= eq_acc;
                    gt    <= gt_acc;
                    lt    <= ~eq_acc & ~gt_acc;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // Accepting start overrides the IDLE/DONE defaults above. This
            // path serves both a fresh start and a back-to-back start.
            if (accept) begin
                a_sh   <= a;
                b_sh   <= b;
                eq_acc <= 1'b1;
                gt_acc <= 1'b0;
                cnt    <= CNT_W'(WIDTH - 1);
                state  <= RUN;
                busy   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_mag_compare_ctrl.sv
// ----------------------------------------------------------------------------
// tb_serial_mag_compare_ctrl
//
// Directed bench for serial_mag_compare_ctrl with WIDTH=8. Expected latencies
// follow the SERCMP_EARLY_EXIT_EN setting the bench is compiled with.
//
// Latency convention: "lat" counts negedges after the accepting posedge.
// lat=0 is the negedge right after that edge. done is expected at lat=9
// (WIDTH+1) for a full-length operation.
// ----------------------------------------------------------------------------
module tb_serial_mag_compare_ctrl;

    localparam int WIDTH = 8;

`ifdef SERCMP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             eq;
    logic             gt;
    logic             lt;

    int n_assert;
    int n_fail;

    serial_mag_compare_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .eq    (eq),
        .gt    (gt),
        .lt    (lt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Wait (bounded) for done. Returns how many negedges elapsed and how many
    // of the samples before done showed busy high.
    task automatic wait_done(input string tag, output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && lat < 64) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    endtask

    // Single operation: one-cycle start, then check latency, busy length,
    // the result flags, and that done is a one-cycle pulse.
    task automatic run_single(input string tag, input logic [7:0] av, input logic [7:0] bv,
                              input logic [2:0] exp_egl, input int exp_lat);
        int lat;
        int bc;
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        wait_done(tag, lat, bc);
        check({tag, "_lat"},  lat, exp_lat);
        check({tag, "_busy"}, bc,  exp_lat - 1);
        check({tag, "_egl"},  {29'd0, eq, gt, lt}, {29'd0, exp_egl});
        @(negedge clk);
        check({tag, "_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int  lat;
        int  bc;
        int  n;
        bit  held;
        bit  done_early;

        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;

        // 1: reset values, then a quiet IDLE with start low.
        repeat (2) @(negedge clk);
        check("rst_outs", {27'd0, busy, done, eq, gt, lt}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_quiet", {27'd0, busy, done, eq, gt, lt}, 32'd0);
        end

        // 2: equal operands take the full length.
        run_single("eq_5a", 8'h5A, 8'h5A, 3'b100, 9);

        // 3: difference in the MSB.
        run_single("gt_80_7f", 8'h80, 8'h7F, 3'b010, EARLY ? 2 : 9);

        // 4: start held high through busy; the first op must not be recaptured.
        //    A start in DONE launches the next op (FF vs 00) with no IDLE cycle.
        @(negedge clk);
        a     = 8'h01;
        b     = 8'h02;
        start = 1'b1;
        @(negedge clk);
        a     = 8'hFF;
        b     = 8'h00;
        wait_done("lt_01_02", lat, bc);
        check("lt_01_02_lat", lat, EARLY ? 8 : 9);
        check("lt_01_02_egl", {29'd0, eq, gt, lt}, 32'b001);
        check("b2b_busy_at_done", {31'd0, busy}, 32'd1);
        start = 1'b0;
        @(negedge clk);
        check("b2b_pulse", {31'd0, done}, 32'd0);
        wait_done("gt_ff_00", lat, bc);
        check("gt_ff_00_lat", lat, EARLY ? 1 : 8);
        check("gt_ff_00_egl", {29'd0, eq, gt, lt}, 32'b010);

        // 5: reset in the 4th RUN cycle aborts the operation.
        @(negedge clk);
        a          = 8'hFF;
        b          = 8'h00;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        done_early = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_early = 1'b1;
        end
        rst_n = 1'b0;
        #1;
        check("abort_outs", {27'd0, busy, done, eq, gt, lt}, 32'd0);
        if (!EARLY) check("abort_no_done_before", {31'd0, done_early}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_early = 1'b1;
        end
        if (!EARLY) check("abort_no_done_after", {31'd0, done_early}, 32'd0);
        check("abort_idle", {27'd0, busy, done, eq, gt, lt}, 32'd0);
        run_single("eq_10", 8'h10, 8'h10, 3'b100, 9);

        // 6: back-to-back 3 vs 9, then 9 vs 3. lt must hold while the second
        //    op runs.
        @(negedge clk);
        a     = 8'd3;
        b     = 8'd9;
        start = 1'b1;
        @(negedge clk);
        a     = 8'd9;
        b     = 8'd3;
        wait_done("b2b_lt", lat, bc);
        check("b2b_lt_lat", lat, EARLY ? 6 : 9);
        check("b2b_lt_egl", {29'd0, eq, gt, lt}, 32'b001);
        check("b2b_lt_busy", {31'd0, busy}, 32'd1);
        start = 1'b0;
        held  = 1'b1;
        n     = 0;
        do begin
            @(negedge clk);
            n++;
            if (done !== 1'b1 && {eq, gt, lt} !== 3'b001) held = 1'b0;
        end while (done !== 1'b1 && n < 64);
        check("b2b_hold", {31'd0, held}, 32'd1);
        check("b2b_gt_lat", n, EARLY ? 6 : 9);
        check("b2b_gt_egl", {29'd0, eq, gt, lt}, 32'b010);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
